// File: rtl/multi_channel_lockin.sv
// multi_channel_lockin: time-multiplexed lock-in demodulator for NUM_CH channels.
// One multiplier pair is shared across channels. X = LPF(data*sin) and Y = LPF(data*cos)
// are computed per channel, and all channels are published together with done_o.
// Build option: define MCLOCKIN_LPF_EN to enable the first-order IIR. When it is undefined,
// the outputs are the raw saturated products.
module multi_channel_lockin #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned BITS      = 24,
    parameter int unsigned LPF_SHIFT = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   tick_i,
    input  logic [NUM_CH*BITS-1:0] data_i,
    input  logic [BITS-1:0]        sin_i,
    input  logic [BITS-1:0]        cos_i,
    output logic [NUM_CH*BITS-1:0] x_o,
    output logic [NUM_CH*BITS-1:0] y_o,
    output logic                   done_o,
    output logic                   busy_o,
    output logic                   overrun_o,
    input  logic                   overrun_clr_i,
    output logic [31:0]            count_o
);

    localparam int unsigned SW = BITS + LPF_SHIFT;
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        OUT
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            ch_q;
    logic [NUM_CH*BITS-1:0]   data_q;
    logic signed [BITS-1:0]   sin_q;
    logic signed [BITS-1:0]   cos_q;
    logic signed [BITS-1:0]   p_x_q;
    logic signed [BITS-1:0]   p_y_q;
    logic signed [SW-1:0]     s_x_q [NUM_CH];
    logic signed [SW-1:0]     s_y_q [NUM_CH];

    logic signed [BITS-1:0]   d_sel;
    logic signed [BITS-1:0]   p_x_d;
    logic signed [BITS-1:0]   p_y_d;
    logic signed [SW-1:0]     s_x_d;
    logic signed [SW-1:0]     s_y_d;

    // Full-width signed product, floored by BITS-1, clamped to the BITS range.
    // Only -max * -max can overflow, but the clamp is written generally.
    function automatic logic signed [BITS-1:0] mul_sat(input logic signed [BITS-1:0] a,
                                                       input logic signed [BITS-1:0] b);
        logic signed [2*BITS-1:0] full;
        logic signed [2*BITS-1:0] sh;
        logic signed [BITS-1:0]   res;
        full = $signed({{BITS{a[BITS-1]}}, a}) * $signed({{BITS{b[BITS-1]}}, b});
        sh   = full >>> (BITS - 1);
        if (sh[2*BITS-1:BITS-1] == {(BITS+1){sh[2*BITS-1]}}) begin
            res = sh[BITS-1:0];
        end else if (sh[2*BITS-1]) begin
            res = {1'b1, {(BITS-1){1'b0}}};
        end else begin
            res = {1'b0, {(BITS-1){1'b1}}};
        end
        return res;
    endfunction

    // Select the active channel from the latched sample set and form both products.
    always_comb begin
        d_sel = data_q[ch_q*BITS +: BITS];
        p_x_d = mul_sat(d_sel, sin_q);
        p_y_d = mul_sat(d_sel, cos_q);
    end

    // Next filter state for the active channel.
    always_comb begin
        s_x_d = '0;
        s_y_d = '0;
`ifdef MCLOCKIN_LPF_EN
        s_x_d = s_x_q[ch_q] + $signed({{LPF_SHIFT{p_x_q[BITS-1]}}, p_x_q})
                - (s_x_q[ch_q] >>> LPF_SHIFT);
        s_y_d = s_y_q[ch_q] + $signed({{LPF_SHIFT{p_y_q[BITS-1]}}, p_y_q})
                - (s_y_q[ch_q] >>> LPF_SHIFT);
`else
        // Bypass: store the product pre-scaled so the shared output path yields it unchanged.
        s_x_d = {p_x_q, {LPF_SHIFT{1'b0}}};
        s_y_d = {p_y_q, {LPF_SHIFT{1'b0}}};
`endif
    end

    // Sequencer: latch, multiply, accumulate per channel, then publish all outputs at once.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            data_q    <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            p_x_q     <= '0;
            p_y_q     <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                s_x_q[k] <= '0;
                s_y_q[k] <= '0;
            end
            x_o       <= '0;
            y_o       <= '0;
            done_o    <= 1'b0;
            busy_o    <= 1'b0;
            overrun_o <= 1'b0;
            count_o   <= '0;
        end else begin
            done_o <= 1'b0;

            // A dropped tick takes priority over a clear in the same cycle.
            if (tick_i && (state_q != IDLE)) begin
                overrun_o <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_o <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    busy_o <= tick_i;
                    if (tick_i) begin
                        data_q  <= data_i;
                        sin_q   <= sin_i;
                        cos_q   <= cos_i;
                        ch_q    <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    p_x_q   <= p_x_d;
                    p_y_q   <= p_y_d;
                    state_q <= ACC;
                end
                ACC: begin
                    s_x_q[ch_q] <= s_x_d;
                    s_y_q[ch_q] <= s_y_d;
                    if (ch_q == CW'(NUM_CH - 1)) begin
                        state_q <= OUT;
                    end else begin
                        ch_q    <= ch_q + CW'(1);
                        state_q <= MUL;
                    end
                end
                OUT: begin
                    // Filtered value is s >>> LPF_SHIFT, i.e. the top BITS bits of s.
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        x_o[k*BITS +: BITS] <= s_x_q[k][SW-1 -: BITS];
                        y_o[k*BITS +: BITS] <= s_y_q[k][SW-1 -: BITS];
                    end
                    done_o  <= 1'b1;
                    count_o <= count_o + 32'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_lockin.sv
// Self-checking bench for multi_channel_lockin (NUM_CH=2, BITS=24, LPF_SHIFT=2).
// The reference model works directly on integers with plain arithmetic. It follows
// MCLOCKIN_LPF_EN the same way the design does.
module tb_multi_channel_lockin;

    localparam int N = 2;
    localparam int B = 24;
    localparam int L = 2;
    localparam longint MAXV = (longint'(1) <<< (B - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (B - 1));

    logic           clk;
    logic           rst_n;
    logic           tick;
    logic [N*B-1:0] data;
    logic [B-1:0]   sin_v;
    logic [B-1:0]   cos_v;
    logic [N*B-1:0] x_o;
    logic [N*B-1:0] y_o;
    logic           done;
    logic           busy;
    logic           overrun;
    logic           clr;
    logic [31:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    longint      mx [N];
    longint      my [N];
    longint      mcount;
`ifdef MCLOCKIN_LPF_EN
    longint      ms_x [N];
    longint      ms_y [N];
`endif

    multi_channel_lockin #(
        .NUM_CH    (N),
        .BITS      (B),
        .LPF_SHIFT (L)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .tick_i        (tick),
        .data_i        (data),
        .sin_i         (sin_v),
        .cos_i         (cos_v),
        .x_o           (x_o),
        .y_o           (y_o),
        .done_o        (done),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .overrun_clr_i (clr),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint chan(input logic [N*B-1:0] v, input int k);
        logic signed [B-1:0] t;
        t = v[k*B +: B];
        return longint'(t);
    endfunction

    function automatic logic [N*B-1:0] pack2(input longint d0, input longint d1);
        logic [B-1:0] a;
        logic [B-1:0] b;
        a = B'(d0);
        b = B'(d1);
        return {b, a};
    endfunction

    function automatic longint sat_prod(input longint a, input longint b);
        longint p;
        p = (a * b) >>> (B - 1);
        if (p > MAXV) p = MAXV;
        if (p < MINV) p = MINV;
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mx[k] = 0;
            my[k] = 0;
`ifdef MCLOCKIN_LPF_EN
            ms_x[k] = 0;
            ms_y[k] = 0;
`endif
        end
        mcount = 0;
    endtask

    task automatic model_apply(input logic [N*B-1:0] dp, input logic [B-1:0] sv,
                               input logic [B-1:0] cv);
        longint s;
        longint c;
        s = chan({{(N-1)*B{1'b0}}, sv}, 0);
        c = chan({{(N-1)*B{1'b0}}, cv}, 0);
        for (int k = 0; k < N; k++) begin
            longint px;
            longint py;
            px = sat_prod(chan(dp, k), s);
            py = sat_prod(chan(dp, k), c);
`ifdef MCLOCKIN_LPF_EN
            ms_x[k] = ms_x[k] + px - (ms_x[k] >>> L);
            ms_y[k] = ms_y[k] + py - (ms_y[k] >>> L);
            mx[k]   = ms_x[k] >>> L;
            my[k]   = ms_y[k] >>> L;
`else
            mx[k] = px;
            my[k] = py;
`endif
        end
        mcount = (mcount + 1) % (longint'(1) <<< 32);
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_x%0d", tag, k), chan(x_o, k), mx[k]);
            check($sformatf("%s_y%0d", tag, k), chan(y_o, k), my[k]);
        end
        check({tag, "_count"}, longint'(count), mcount);
    endtask

    task automatic scramble();
        data  = {$urandom, $urandom};
        sin_v = B'($urandom);
        cos_v = B'($urandom);
    endtask

    // Present one sample set; returns #1 after the accepting edge.
    task automatic send_tick(input logic [N*B-1:0] dp, input logic [B-1:0] sv,
                             input logic [B-1:0] cv);
        @(negedge clk);
        data  = dp;
        sin_v = sv;
        cos_v = cv;
        tick  = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        scramble();
        check("busy_on_tick", longint'(busy), 1);
        model_apply(dp, sv, cv);
    endtask

    // Wait (bounded) for done_o, checking latency from the edge last observed.
    task automatic finish_set(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
        check({tag, "_latency"}, longint'(lat), longint'(exp_lat));
        check({tag, "_busy_done"}, longint'(busy), 1);
        check_outputs(tag);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, longint'(done), 0);
        check({tag, "_busy_idle"}, longint'(busy), 0);
    endtask

    function automatic logic [B-1:0] rnd_val();
        logic [B-1:0] v;
        v = B'($urandom);
        if ($urandom_range(0, 7) == 0) v = B'(MINV);
        if ($urandom_range(0, 7) == 0) v = B'(MAXV);
        return v;
    endfunction

    initial begin
        logic [N*B-1:0] dir;
        int             dones;
        longint         diff;

        rst_n = 1'b0;
        tick  = 1'b0;
        clr   = 1'b0;
        data  = '0;
        sin_v = '0;
        cos_v = '0;
        model_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("reset");
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_overrun", longint'(overrun), 0);

        // Directed single tick.
        dir = pack2(4194304, -4194304);
        send_tick(dir, B'(MAXV), '0);
        finish_set("dir1", 2 * N + 1);
`ifdef MCLOCKIN_LPF_EN
        check("dir1_x0_const", chan(x_o, 0), 1048575);
`else
        check("dir1_x0_const", chan(x_o, 0), 4194303);
        check("dir1_x1_const", chan(x_o, 1), -4194304);
`endif
        send_tick(dir, B'(MAXV), '0);
        finish_set("dir2", 2 * N + 1);
`ifdef MCLOCKIN_LPF_EN
        check("dir2_x0_const", chan(x_o, 0), 1835007);
        for (int i = 0; i < 38; i++) begin
            send_tick(dir, B'(MAXV), '0);
            finish_set("iir", 2 * N + 1);
        end
        diff = chan(x_o, 0) - 4194303;
        if (diff < 0) diff = -diff;
        check("iir_settled", longint'(diff <= 3), 1);
`else
        check("dir2_x0_const", chan(x_o, 0), 4194303);
`endif

        // Saturation corner: -max * -max.
        send_tick(pack2(MINV, MINV), B'(MINV), B'(MINV));
        finish_set("sat", 2 * N + 1);
`ifndef MCLOCKIN_LPF_EN
        check("sat_x0_const", chan(x_o, 0), MAXV);
`endif

        // Randomized sample sets.
        for (int i = 0; i < 25; i++) begin
            send_tick({rnd_val(), rnd_val()}, rnd_val(), rnd_val());
            finish_set($sformatf("rnd%0d", i), 2 * N + 1);
        end

        // Overrun: extra ticks at T+3 (dropped) and T+6 (minimum spacing, accepted).
        send_tick({rnd_val(), rnd_val()}, rnd_val(), rnd_val());
        dones = 0;
        dir   = {rnd_val(), rnd_val()};
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            if (e == 3) begin
                scramble();
                tick = 1'b1;
            end
            if (e == 6) begin
                data  = dir;
                sin_v = B'(MAXV);
                cos_v = B'(MINV);
                tick  = 1'b1;
            end
            @(posedge clk);
            #1;
            tick = 1'b0;
            if (done) dones++;
        end
        check("ovr_dones", longint'(dones), 1);
        check("ovr_flag", longint'(overrun), 1);
        check_outputs("ovr_first");
        model_apply(dir, B'(MAXV), B'(MINV));
        finish_set("ovr_second", 2 * N + 1);
        check("ovr_sticky", longint'(overrun), 1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("ovr_clear", longint'(overrun), 0);

        // Clear coinciding with a new overrun: the set wins.
        send_tick({rnd_val(), rnd_val()}, rnd_val(), rnd_val());
        @(negedge clk);
        tick = 1'b1;
        clr  = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        clr  = 1'b0;
        check("ovr_set_wins", longint'(overrun), 1);
        finish_set("ovr_race", 2 * N);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("ovr_clear2", longint'(overrun), 0);

        // Reset mid-operation.
        @(negedge clk);
        data  = {rnd_val(), rnd_val()};
        sin_v = rnd_val();
        cos_v = rnd_val();
        tick  = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("midrst");
        check("midrst_busy", longint'(busy), 0);
        dones = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midrst_no_done", longint'(dones), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_tick({rnd_val(), rnd_val()}, rnd_val(), rnd_val());
        finish_set("post_rst", 2 * N + 1);
        check("post_rst_count1", longint'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
